// File: rtl/cbb_pkg.sv
// Shared constants for the RAM stream reader: FSM encoding and output-buffer sizing.
package cbb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } rsr_state_t;

   localparam int RSR_BUF_DEPTH   = 4;
   localparam int RSR_PTR_W       = $clog2(RSR_BUF_DEPTH);
   localparam int RSR_CNT_W       = RSR_PTR_W + 1;
   // buffered words plus the read in flight must stay below this to issue another read
   localparam int RSR_ISSUE_LIMIT = 3;

endpackage

// File: rtl/stream_buf_fifo.sv
// Small synchronous FIFO of {last, data} words; the head entry drives the stream outputs.
module stream_buf_fifo
   import cbb_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_wr_en,
   input  logic                  i_wr_last,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last,
   output logic [RSR_CNT_W-1:0]  o_count
);

   logic [DATA_WIDTH:0]  r_mem [RSR_BUF_DEPTH];
   logic [RSR_PTR_W-1:0] r_wr_ptr;
   logic [RSR_PTR_W-1:0] r_rd_ptr;
   logic [RSR_CNT_W-1:0] r_count;
   logic                 w_rd;

   assign w_rd = i_rd_en && (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RSR_BUF_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_wr_en) begin
            r_mem[r_wr_ptr] <= {i_wr_last, i_wr_data};
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_wr_en, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid          = (r_count != '0);
   assign {o_last, o_data} = r_mem[r_rd_ptr];
   assign o_count          = r_count;

   // the reader's issue throttle keeps this from ever happening
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_wr_en && !w_rd && (r_count == RSR_CNT_W'(RSR_BUF_DEPTH))));

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a (start, length) window out of a registered-read RAM and streams it with backpressure.
//   state    | meaning
//   ST_IDLE  | ready for a command
//   ST_READ  | issuing RAM reads, throttled by buffer room
//   ST_DRAIN | all reads issued; waiting for the buffer to empty
module ram_stream_reader
   import cbb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  ram_enb,
   output logic [ADDR_WIDTH-1:0] ram_addrb,
   input  logic [DATA_WIDTH-1:0] ram_doutb,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   rsr_state_t            r_state;
   rsr_state_t            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_rem;
   logic                  r_pending;
   logic                  r_last_pend;
   logic                  r_done;
   logic [RSR_CNT_W-1:0]  w_buf_count;
   logic [RSR_CNT_W-1:0]  w_occ;
   logic                  w_accept;
   logic                  w_issue;
   logic                  w_last_issue;
   logic                  w_pop;
   logic                  w_drained;

   // occupancy uses only registered terms so m_ready never reaches ram_enb
   assign w_occ        = w_buf_count + {{(RSR_CNT_W-1){1'b0}}, r_pending};
   assign w_accept     = cmd_valid && (r_state == ST_IDLE);
   assign w_issue      = (r_state == ST_READ) && (w_occ < RSR_CNT_W'(RSR_ISSUE_LIMIT));
   assign w_last_issue = w_issue && (r_rem == LEN_WIDTH'(1));
   assign w_pop        = m_valid && m_ready;
   assign w_drained    = !r_pending &&
                         ((w_buf_count == '0) || ((w_buf_count == RSR_CNT_W'(1)) && w_pop));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_state_nxt = (cmd_len != '0) ? ST_READ : ST_DRAIN;
         ST_READ:  if (w_last_issue) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_drained) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      ram_enb   = 1'b0;
      busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = rst_n;
            busy      = 1'b0;
         end
         ST_READ: ram_enb = w_issue;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_rem       <= '0;
         r_pending   <= 1'b0;
         r_last_pend <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr <= cmd_addr;
            r_rem  <= cmd_len;
         end else if (w_issue) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
         end
         r_pending   <= w_issue;
         r_last_pend <= w_last_issue;
         r_done      <= (r_state == ST_DRAIN) && w_drained;
      end
   end

   assign ram_addrb = r_addr;
   assign done      = r_done;

   stream_buf_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (r_pending),
      .i_wr_last (r_last_pend),
      .i_wr_data (ram_doutb),
      .i_rd_en   (w_pop),
      .o_valid   (m_valid),
      .o_data    (m_data),
      .o_last    (m_last),
      .o_count   (w_buf_count)
   );

endmodule
